// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier / Barrett reduction datapath.
//   DATA_LENGTH          default operand width
//   BL_W                 width of bit-length values and the divider bit counter
//   barrett_pre_state_e  control states of barrett_precompute
package multiplier_pkg;

  localparam int unsigned DATA_LENGTH = 32;

  // Holds 2k for k up to DATA_LENGTH, plus headroom for the bit counter.
  localparam int unsigned BL_W = $clog2(DATA_LENGTH) + 2;

  typedef enum logic [1:0] {
    StIdle,
    StBitlen,
    StDivide,
    StDone
  } barrett_pre_state_e;

endpackage

// File: rtl/barrett_precompute_bitlen_enc.sv
// bitlen_enc: combinational MSB priority encoder.
//   val_i  [DW-1:0]    operand
//   bl_o   [BL_W-1:0]  index of the highest set bit plus one; 0 when val_i == 0
module bitlen_enc
  import multiplier_pkg::*;
#(
  parameter int unsigned DW = DATA_LENGTH
) (
  input  logic [DW-1:0]   val_i,
  output logic [BL_W-1:0] bl_o
);

  // Ascending scan: the last set bit seen is the most significant one.
  always_comb begin
    bl_o = '0;
    for (int unsigned b = 0; b < DW; b++) begin
      if (val_i[b]) begin
        bl_o = BL_W'(b + 1);
      end
    end
  end

endmodule

// File: rtl/barrett_precompute.sv
// barrett_precompute: computes Barrett constants k = bitlen(m) and mu = floor(2^(2k)/m)
// with a bit-serial restoring divider, behind valid/ready handshakes.
//   clk_i, rst_ni           clock, synchronous active-low reset
//   in_valid_i/in_ready_o   modulus handshake; ready only while idle
//   m_i                     modulus
//   out_valid_o/out_ready_i result handshake
//   m_o, m_bl_o, mu_o       captured modulus, bit length k, mu
//   error_o                 modulus rejected (m == 0 or k > DW-2)
// Optional macro BARRETT_PRE_CACHE_EN adds a single-entry cache of the last
// successful {m, k, mu}; a hit goes straight to DONE.
module barrett_precompute
  import multiplier_pkg::*;
#(
  parameter int unsigned DW = DATA_LENGTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] m_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] m_o,
  output logic [DW-1:0] m_bl_o,
  output logic [DW-1:0] mu_o,
  output logic          error_o
);

  barrett_pre_state_e state_q, state_d;
  logic [DW-1:0]   m_q, m_d;
  logic [DW-1:0]   bl_q, bl_d;
  logic [DW-1:0]   mu_q, mu_d;   // doubles as the quotient register during DIVIDE
  logic            err_q, err_d;
  logic [DW:0]     r_q, r_d;
  logic [BL_W-1:0] k_q, k_d;
  logic [BL_W-1:0] i_q, i_d;
  logic [BL_W-1:0] k_enc;
  logic [DW+1:0]   r_shift;
  logic            n_bit;
  logic            q_bit;
  logic            cache_hit;

`ifdef BARRETT_PRE_CACHE_EN
  logic            cache_vld_q, cache_vld_d;
  logic [DW-1:0]   cache_m_q, cache_m_d;
  logic [BL_W-1:0] cache_k_q, cache_k_d;
  logic [DW-1:0]   cache_mu_q, cache_mu_d;

  assign cache_hit = cache_vld_q && (m_i == cache_m_q);
`else
  assign cache_hit = 1'b0;
`endif

  bitlen_enc #(
    .DW(DW)
  ) u_bitlen_enc (
    .val_i(m_q),
    .bl_o (k_enc)
  );

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign m_o         = m_q;
  assign m_bl_o      = bl_q;
  assign mu_o        = mu_q;
  assign error_o     = err_q;

  // Dividend is 2^(2k): its only set bit is at position 2k.
  assign n_bit   = (i_q == (k_q << 1));
  assign r_shift = {r_q, n_bit};
  assign q_bit   = (r_shift >= {2'b00, m_q});

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    bl_d    = bl_q;
    mu_d    = mu_q;
    err_d   = err_q;
    r_d     = r_q;
    k_d     = k_q;
    i_d     = i_q;
`ifdef BARRETT_PRE_CACHE_EN
    cache_vld_d = cache_vld_q;
    cache_m_d   = cache_m_q;
    cache_k_d   = cache_k_q;
    cache_mu_d  = cache_mu_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          m_d     = m_i;
          state_d = StBitlen;
          if (cache_hit) begin
`ifdef BARRETT_PRE_CACHE_EN
            bl_d  = DW'(cache_k_q);
            mu_d  = cache_mu_q;
            err_d = 1'b0;
`endif
            state_d = StDone;
          end
        end
      end
      StBitlen: begin
        k_d  = k_enc;
        bl_d = DW'(k_enc);
        // mu can reach 2^(k+1), so k must leave one spare bit below DW.
        if (m_q == '0 || k_enc > BL_W'(DW - 2)) begin
          mu_d    = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          mu_d    = '0;
          err_d   = 1'b0;
          r_d     = '0;
          i_d     = k_enc << 1;
          state_d = StDivide;
        end
      end
      StDivide: begin
        r_d  = q_bit ? (DW+1)'(r_shift - {2'b00, m_q}) : (DW+1)'(r_shift);
        mu_d = {mu_q[DW-2:0], q_bit};
        i_d  = i_q - 1'b1;
        if (i_q == '0) begin
          state_d = StDone;
`ifdef BARRETT_PRE_CACHE_EN
          cache_vld_d = 1'b1;
          cache_m_d   = m_q;
          cache_k_d   = k_q;
          cache_mu_d  = {mu_q[DW-2:0], q_bit};
`endif
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      m_q     <= '0;
      bl_q    <= '0;
      mu_q    <= '0;
      err_q   <= 1'b0;
      r_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      bl_q    <= bl_d;
      mu_q    <= mu_d;
      err_q   <= err_d;
      r_q     <= r_d;
      k_q     <= k_d;
      i_q     <= i_d;
    end
  end

`ifdef BARRETT_PRE_CACHE_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cache_vld_q <= 1'b0;
      cache_m_q   <= '0;
      cache_k_q   <= '0;
      cache_mu_q  <= '0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_m_q   <= cache_m_d;
      cache_k_q   <= cache_k_d;
      cache_mu_q  <= cache_mu_d;
    end
  end
`endif

endmodule

// File: tb/tb_barrett_precompute.sv
// Testbench for barrett_precompute: directed moduli with literal expectations, plus a
// reference model (plain arithmetic) checked against the outputs on every valid cycle.
module tb_barrett_precompute;

  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [DW-1:0] m;
    logic [DW-1:0] bl;
    logic [DW-1:0] mu;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] m_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] m_out, bl_out, mu_out;
  logic          err_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  res_t exp_q[$];
  int rise_cyc[$];
  logic prev_valid = 1'b0;
  logic [DW-1:0] last_mu, last_bl;

  barrett_precompute #(
    .DW(DW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .m_i        (m_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .m_o        (m_out),
    .m_bl_o     (bl_out),
    .mu_o       (mu_out),
    .error_o    (err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: k from the highest set bit, mu by 64-bit integer division.
  function automatic res_t model(input logic [DW-1:0] m);
    res_t r;
    int k;
    logic [63:0] num;
    k = 0;
    for (int b = 0; b < DW; b++) if (m[b]) k = b + 1;
    r.m  = m;
    r.bl = DW'(k);
    if (m == 0 || k > DW - 2) begin
      r.err = 1'b1;
      r.mu  = '0;
    end else begin
      r.err = 1'b0;
      num   = 64'd1 << (2 * k);
      r.mu  = DW'(num / {32'd0, m});
    end
    return r;
  endfunction

  // Acceptance is decided at the next rising edge from inputs already stable here.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) exp_q.push_back(model(m_in));
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        chk("mon_m", m_out, exp_q[0].m);
        chk("mon_bl", bl_out, exp_q[0].bl);
        chk("mon_mu", mu_out, exp_q[0].mu);
        chk("mon_err", err_out, exp_q[0].err);
        chk("mon_busy_ready", in_ready, 0);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (out_valid && !prev_valid) rise_cyc.push_back(cyc);
    prev_valid <= out_valid;
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL wait_ready actual=0 required=1");
    end
  endtask

  task automatic op(input logic [DW-1:0] m, input int ebl, input logic [DW-1:0] emu,
                    input int eerr, input int elat, input int stall);
    int lat;
    wait_idle();
    @(posedge clk);
    #1 in_valid = 1'b1;
    m_in = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 300);
    chk($sformatf("latency_m%0h", m), lat, elat);
    chk($sformatf("bl_m%0h", m), bl_out, ebl);
    chk($sformatf("mu_m%0h", m), mu_out, emu);
    chk($sformatf("err_m%0h", m), err_out, eerr);
    last_mu = mu_out;
    last_bl = bl_out;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1 in_valid = 1'b1;
      m_in = 32'h5;
      @(negedge clk);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  initial begin
    res_t t;
    longint x, q, r;
    int n;

    // Pin the model to hand-computed values.
    t = model(32'd13);
    chk("model13_mu", t.mu, 19);
    chk("model13_bl", t.bl, 4);
    t = model(32'd1);
    chk("model1_mu", t.mu, 4);
    t = model(32'h3FFFFFFF);
    chk("model3fff_mu", t.mu, 32'h40000001);
    t = model(32'd7);
    chk("model7_mu", t.mu, 9);
    t = model(32'h40000000);
    chk("model4000_err", t.err, 1);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_m", m_out, 0);
    chk("rst_bl", bl_out, 0);
    chk("rst_mu", mu_out, 0);
    chk("rst_err", err_out, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    op(32'd13, 4, 32'd19, 0, 11, 0);
    // Feed the result into a Barrett reduction of x = 150.
    x = 150;
    q = ((x >> (last_bl - 1)) * longint'(last_mu)) >> (last_bl + 1);
    r = x - q * 13;
    n = 0;
    while (r >= 13 && n < 4) begin
      r = r - 13;
      n++;
    end
    chk("barrett_150_mod_13", r, 7);

    op(32'd1, 1, 32'd4, 0, 5, 0);
    op(32'h3FFFFFFF, 30, 32'h40000001, 0, 63, 0);
    op(32'd0, 0, 32'd0, 1, 2, 0);
    op(32'h40000000, 31, 32'd0, 1, 2, 0);

    // Backpressure: 10 stalled cycles with a competing input offered.
    op(32'd13, 4, 32'd19, 0, 11, 10);

    // Reset mid-DIVIDE discards the operation.
    wait_idle();
    @(posedge clk);
    #1 in_valid = 1'b1;
    m_in = 32'd13;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk("inflight_novalid", out_valid, 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_m", m_out, 0);
    chk("midrst_bl", bl_out, 0);
    chk("midrst_mu", mu_out, 0);
    chk("midrst_err", err_out, 0);
    op(32'd7, 3, 32'd9, 0, 9, 0);

    // Back-to-back throughput with both handshakes held high.
    rise_cyc.delete();
    @(posedge clk);
    #1 in_valid = 1'b1;
    m_in = 32'd7;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1 out_ready = 1'b0;
    if (rise_cyc.size() < 2) begin
      total++;
      bad++;
      $display("FAIL throughput_rises actual=%0d required=2+", rise_cyc.size());
    end else begin
`ifdef BARRETT_PRE_CACHE_EN
      chk("throughput", rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2], 2);
`else
      chk("throughput", rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2], 10);
`endif
    end

`ifdef BARRETT_PRE_CACHE_EN
    op(32'd13, 4, 32'd19, 0, 11, 0);
    op(32'd13, 4, 32'd19, 0, 1, 0);
    op(32'd0, 0, 32'd0, 1, 2, 0);
    op(32'd13, 4, 32'd19, 0, 1, 0);
`endif

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrett_precompute.md
# barrett_precompute

Sequential front-end for the Barrett reduction datapath. Per modulus it computes the constants the combinational `barrett_parallel` stage consumes: the bit length `k` of `m`, and `mu = floor(2^(2k) / m)`. It uses a bit-serial restoring divider behind valid/ready handshakes. Its outputs connect directly to `m_i`, `m_bl_i` and `mu_i` of the reduction stage.

## Interface
- `DW`, default `DATA_LENGTH` (from `multiplier_pkg`): operand width; all data ports are `DW` bits.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `in_valid_i`  in  1  a modulus is offered on `m_i`.
- `in_ready_o`  out  1  block can accept a modulus; high only in IDLE.
- `m_i`  in  DW  modulus.
- `out_valid_o`  out  1  result registers hold a valid result.
- `out_ready_i`  in  1  consumer accepts the result.
- `m_o`  out  DW  captured modulus, passed through with the result.
- `m_bl_o`  out  DW  `k`, the bit length of `m`, zero-extended.
- `mu_o`  out  DW  `floor(2^(2k)/m)`.
- `error_o`  out  1  modulus rejected; qualified by `out_valid_o`.

## Operation
- State machine: IDLE → BITLEN → DIVIDE → DONE → IDLE.
- **IDLE:** `in_ready_o = 1`. On `in_valid_i && in_ready_o`, register `m_i` and go to BITLEN.
- **BITLEN:** one cycle.
  - `k` = index of the most significant set bit of `m`, plus 1 (priority encoder).
  - Error if `m == 0` or `k > DW-2`, because `mu ≤ 2^(k+1)` must fit in `DW` bits. On error, set `mu = 0`, `m_bl = k` (0 when `m == 0`), `error = 1`, and go to DONE.
  - Otherwise clear the remainder, clear the quotient, set the bit counter `i = 2k`, and go to DIVIDE.
- **DIVIDE:** one quotient bit per cycle, `2k+1` cycles (`i = 2k` down to 0).
  - The dividend `N = 2^(2k)`, so `N[i]` is 1 only when `i == 2k`.
  - Each cycle: `r' = (r << 1) | N[i]`.
  - If `r' ≥ m`: `r = r' − m` and `q[i] = 1`; else `r = r'` and `q[i] = 0`.
  - The remainder register is `DW+1` bits so `r'` never overflows.
  - After the `i == 0` iteration, go to DONE.
- **DONE:** `out_valid_o = 1`. `m_o`, `m_bl_o`, `mu_o` and `error_o` are stable until `out_valid_o && out_ready_i`, then the state returns to IDLE.
- No new input is accepted while busy: `in_ready_o = 0` in BITLEN, DIVIDE and DONE. There is no same-cycle output/input overlap.
- **Reset:** `rst_ni = 0` at any edge, including mid-DIVIDE or in DONE, forces IDLE. The in-flight operation is discarded and no output is produced for it.
- **Reset values:** `in_ready_o = 1` (IDLE), `out_valid_o = 0`, `m_o = 0`, `m_bl_o = 0`, `mu_o = 0`, `error_o = 0`.

## Timing
- Input accepted at edge 0.
- BITLEN occupies cycle 1.
- DIVIDE occupies cycles 2 .. 2k+2.
- `out_valid_o` rises after edge 2k+3, i.e. latency is `2k+3` cycles from acceptance.
- Error path: `out_valid_o` rises after edge 2.
- Back-to-back throughput: one result per `2k+4` cycles when `out_ready_i` is held high, because of the one IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs except `in_ready_o`, which is decoded from state.

## Configuration
- Macro: `BARRETT_PRE_CACHE_EN`.
- **Defined:** the block keeps a single-entry cache of the last successful `{m, k, mu}` plus a valid bit.
  - The valid bit is cleared by reset; it is not set by error results.
  - If an accepted `m_i` equals the cached `m` and the entry is valid, go straight from IDLE to DONE with the cached values, so `out_valid_o` rises after edge 1.
  - A miss behaves as normal.
  - The cache is written on the DIVIDE → DONE transition.
- **Undefined:** there is no cache, and every modulus takes the full path.

## Structure
- `multiplier_pkg` gains:
  - the state enum `barrett_pre_state_e` (IDLE, BITLEN, DIVIDE, DONE);
  - `localparam BL_W = $clog2(DATA_LENGTH)+2` for the counter `i` and for `k`.
- One natural sub-module: `bitlen_enc`, a combinational MSB priority encoder (`DW` in, `BL_W` out) used in BITLEN.
- The divider stays inline in the FSM.

## Test plan
- `m=13` → `m_bl_o=4`, `mu_o=19`, `error_o=0`, `out_valid_o` 11 cycles after acceptance; feeding the result to `barrett_parallel` with `x=150` gives 7.
- `m=1` → `m_bl_o=1`, `mu_o=4`, latency 5; `m=0x3FFFFFFF` (DW=32) → `m_bl_o=30`, `mu_o=0x40000001`, latency 63.
- `m=0` → `error_o=1`, `mu_o=0`, `m_bl_o=0`, latency 2; `m=0x40000000` (k=31, DW=32) → `error_o=1`, `m_bl_o=31`.
- Backpressure: `out_ready_i=0` for 10 cycles in DONE → outputs stable, `in_ready_o=0`, an offered `in_valid_i` is ignored; after the handshake, IDLE for exactly one cycle.
- `rst_ni=0` for one cycle mid-DIVIDE (`m=13`, cycle 6) → next cycle IDLE, `out_valid_o=0` throughout, all outputs 0; a following `m=7` gives `mu_o=9`, `m_bl_o=3`.
- With `BARRETT_PRE_CACHE_EN`: `m=13`, then `m=13` → second result in 1 cycle with `mu_o=19`; then `m=0`, then `m=13` → cache hit still valid, since errors do not touch the cache.
